tcp_rx_tmp_buf_wr: RTL and testbench
====================================

# tcp_rx_tmp_buf_wr

Receive-side payload writer for the TCP slow path. It accepts a per-packet header (flow, accept decision, payload length) plus the payload beat stream, allocates one temporary-buffer slab from an internal free list, and writes the beats into the slab memory. When the packet is complete it emits one `rx_store_buf_q_struct` entry to the store-buffer queue. Downstream consumers return slabs through a release port.

## Interface
Parameters:
- `DATA_W`, default `MAC_INTERFACE_W` (512): payload beat width; bytes per beat `DATA_W/8`.
- `NUM_SLABS`, default `RX_TMP_BUF_NUM_SLABS` (16): number of slabs.
- `SLAB_BYTES`, default `RX_TMP_BUF_SLAB_BYTES` (2048): bytes per slab.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `src_tmp_buf_hdr_val` in 1: header valid.
- `src_tmp_buf_hdr_flowid` in `FLOWID_W`: flow ID.
- `src_tmp_buf_hdr_accept` in 1: engine accepts the payload.
- `src_tmp_buf_hdr_len` in `PAYLOAD_ENTRY_LEN_W`: payload bytes.
- `tmp_buf_src_hdr_rdy` out 1: header ready.
- `src_tmp_buf_data_val` in 1: beat valid.
- `src_tmp_buf_data` in `DATA_W`: beat data.
- `tmp_buf_src_data_rdy` out 1: beat ready.
- `tmp_buf_mem_wr_val` out 1: memory write strobe.
- `tmp_buf_mem_wr_addr` out `RX_TMP_BUF_MEM_ADDR_W`: beat address.
- `tmp_buf_mem_wr_data` out `DATA_W`: write data.
- `tmp_buf_dst_q_val` out 1: store-queue entry valid.
- `tmp_buf_dst_q_data` out `RX_STORE_BUF_Q_STRUCT_W`: entry.
- `dst_tmp_buf_q_rdy` in 1: queue ready.
- `src_tmp_buf_free_val` in 1: slab release.
- `src_tmp_buf_free_slab` in `RX_TMP_BUF_SLAB_NUM_W`: slab released.
- `tmp_buf_free_cnt` out `RX_TMP_BUF_SLAB_NUM_W+1`: free slabs.

## Operation
- Beats per packet: `ceil(len/(DATA_W/8))`. There is no data last signal; the length alone frames the packet.
- Packet classes:
  - **Store**: `accept=1` and `0 < len <= SLAB_BYTES`. Consumes one slab.
  - **Drop**: `accept=0` with `len > 0`, or `len > SLAB_BYTES`. Beats are drained with no memory writes.
  - **Empty**: `len == 0`. No beats are expected.
- FSM states:
  - **IDLE**: `hdr_rdy = 1` unless the header is Store class and `free_cnt == 0`; in that case it stalls with `hdr_rdy = 0`. On header handshake: Store goes to WRITE and pops the slab; Drop goes to DRAIN; Empty goes to OUT.
  - **WRITE**: `data_rdy = 1`. Each handshake writes address `{slab, beat_idx}` and increments `beat_idx`. The final handshake goes to OUT.
  - **DRAIN**: `data_rdy = 1` with no writes. The final handshake goes to OUT.
  - **OUT**: `q_val = 1` and all rdy outputs are 0. On `q_rdy` it returns to IDLE.
- Entry fields:
  - `flowid`: from the header.
  - `accept_payload`: 1 only for Store class.
  - `payload_addr`: `slab * SLAB_BYTES` zero-extended to 32 bits; 0 for non-Store.
  - `payload_len`: the header `len` for all classes (an oversize length is reported unchanged with `accept=0`).
- Free list: a FIFO of slab numbers holding slabs 0..NUM_SLABS-1 in ascending order after reset.
  - Pop and release in the same cycle are both applied; `free_cnt` is unchanged.
  - A release when `free_cnt == NUM_SLABS`, or of a slab that is already free, is a protocol violation. The behaviour is undefined; the bench must not generate it.
- Reset mid-packet: the FSM returns to IDLE and the free list is fully restored. The remaining beats are the source's responsibility.

## Timing
- Reset values:
  - `hdr_rdy = 1`.
  - `data_rdy`, `mem_wr_val`, `q_val` = 0.
  - `mem_wr_addr`, `mem_wr_data`, `q_data` = 0.
  - `free_cnt = NUM_SLABS`.
- Memory write is registered: `wr_val` and address/data appear 1 cycle after the beat handshake.
- Entry latency:
  - Store/Drop: `q_val` rises in the cycle after the last beat handshake, so it coincides with the registered final write.
  - Empty: `q_val` rises in the cycle after the header handshake.
- `q_data` is held stable while `q_val && !q_rdy`.
- Minimum packet-to-packet gap is 1 cycle (the OUT handshake cycle). The next header is accepted in the cycle after the OUT handshake.
- `free_cnt` updates 1 cycle after a pop or release.

## Configuration
- `TCP_RX_TMP_BUF_STATS_EN`: adds the following outputs, all reset to 0:
  - `tmp_buf_stat_store_cnt` (32 bit): Store headers accepted.
  - `tmp_buf_stat_drop_cnt` (32 bit): Drop headers accepted.
  - `tmp_buf_stat_stall_cycles` (32 bit): cycles in IDLE stalled on `free_cnt == 0`.
- Each counter increments once per event and wraps.
- Without the macro these ports and counters do not exist.

## Structure
- The shared TCP package owns:
  - `rx_store_buf_q_struct` and `payload_buf_struct`.
  - `RX_TMP_BUF_*` constants.
  - A new typedef `rx_tmp_buf_hdr_struct` {flowid, accept, len}.
  - A new FSM state enum `rx_tmp_buf_wr_state_e`.
- One sub-module: `rx_tmp_buf_free_list` (slab FIFO with count, push/pop, reset fill).

## Test plan
- Store, len=130, 64-byte beats: 3 writes at addresses 0, 1, 2; entry {accept=1, addr=0, len=130}; `free_cnt` 16→15.
- Second Store, len=64: 1 write at address 32 (slab 1); entry addr=2048.
- Drop, accept=0, len=200: 4 beats drained, no writes; entry {accept=0, addr=0, len=200}; `free_cnt` unchanged.
- Oversize: accept=1, len=3000: drained (47 beats), entry {accept=0, len=3000}. Empty: len=0 gives an entry 1 cycle after the header.
- Exhaustion: 16 Stores with no release, then a 17th header sees `hdr_rdy = 0`. A release of slab 5 lets the next header proceed, writing to addresses 160+ with entry addr=10240.
- Backpressure and concurrency:
  - `q_rdy = 0` for 5 cycles: `q_data` is held and `hdr_rdy = 0`.
  - Release coinciding with a pop: `free_cnt` is unchanged.
  - `rst` asserted mid-WRITE restores `free_cnt = 16`.

Source files
------------

// File: rtl/tcp_rx_tmp_buf_wr_pkg.sv
// ---------------------------------------------------------------------------
// tcp_rx_tmp_buf_wr_pkg
// Shared TCP receive-path types and constants used by the temporary-buffer
// payload writer:
//   - RX_TMP_BUF_* sizing constants and interface widths
//   - payload_buf_struct / rx_store_buf_q_struct (store-buffer queue entry)
//   - rx_tmp_buf_hdr_struct (per-packet header as seen by the writer)
//   - rx_tmp_buf_wr_state_e (writer FSM states)
//   - rx_tmp_buf_classify() helper (Store / Drop / Empty decision)
// ---------------------------------------------------------------------------
package tcp_rx_tmp_buf_wr_pkg;

    localparam int MAC_INTERFACE_W           = 512;
    localparam int FLOWID_W                  = 12;
    localparam int PAYLOAD_ENTRY_LEN_W       = 16;

    localparam int RX_TMP_BUF_NUM_SLABS      = 16;
    localparam int RX_TMP_BUF_SLAB_BYTES     = 2048;
    localparam int RX_TMP_BUF_SLAB_NUM_W     = $clog2(RX_TMP_BUF_NUM_SLABS);
    localparam int RX_TMP_BUF_BEATS_PER_SLAB = RX_TMP_BUF_SLAB_BYTES / (MAC_INTERFACE_W / 8);
    localparam int RX_TMP_BUF_MEM_ADDR_W     = RX_TMP_BUF_SLAB_NUM_W + $clog2(RX_TMP_BUF_BEATS_PER_SLAB);

    typedef struct packed {
        logic [31:0]                    payload_addr;
        logic [PAYLOAD_ENTRY_LEN_W-1:0] payload_len;
    } payload_buf_struct;

    typedef struct packed {
        logic [FLOWID_W-1:0]            flowid;
        logic                           accept_payload;
        logic [31:0]                    payload_addr;
        logic [PAYLOAD_ENTRY_LEN_W-1:0] payload_len;
    } rx_store_buf_q_struct;

    localparam int RX_STORE_BUF_Q_STRUCT_W = $bits(rx_store_buf_q_struct);

    typedef struct packed {
        logic [FLOWID_W-1:0]            flowid;
        logic                           accept;
        logic [PAYLOAD_ENTRY_LEN_W-1:0] len;
    } rx_tmp_buf_hdr_struct;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } rx_tmp_buf_wr_state_e;

    typedef enum logic [1:0] {
        PKT_STORE = 2'd0,
        PKT_DROP  = 2'd1,
        PKT_EMPTY = 2'd2
    } rx_tmp_buf_pkt_class_e;

    // Empty wins over everything; an oversize accepted packet is drained.
    function automatic rx_tmp_buf_pkt_class_e rx_tmp_buf_classify(
        input rx_tmp_buf_hdr_struct hdr,
        input int unsigned          slab_bytes
    );
        rx_tmp_buf_pkt_class_e cls;
        if (hdr.len == '0)
            cls = PKT_EMPTY;
        else if (hdr.accept && (32'(hdr.len) <= slab_bytes))
            cls = PKT_STORE;
        else
            cls = PKT_DROP;
        return cls;
    endfunction

endpackage

// File: rtl/tcp_rx_tmp_buf_wr_free_list.sv
// ---------------------------------------------------------------------------
// rx_tmp_buf_free_list
// FIFO of free slab numbers. Reset fills it with 0..NUM_SLABS-1 ascending.
// A push and a pop in the same cycle are both applied (count unchanged).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_pop          remove head slab (caller guarantees o_count != 0)
//   o_head         slab number at the head of the list
//   i_push         return i_push_slab to the tail
//   o_count        number of free slabs (registered)
// ---------------------------------------------------------------------------
module rx_tmp_buf_free_list
    import tcp_rx_tmp_buf_wr_pkg::*;
#(
    parameter int NUM_SLABS = RX_TMP_BUF_NUM_SLABS,
    parameter int SLAB_W    = RX_TMP_BUF_SLAB_NUM_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pop,
    output logic [SLAB_W-1:0] o_head,
    input  logic              i_push,
    input  logic [SLAB_W-1:0] i_push_slab,
    output logic [SLAB_W:0]   o_count
);

    logic [SLAB_W-1:0] r_fifo [NUM_SLABS];
    logic [SLAB_W-1:0] r_rd_ptr;
    logic [SLAB_W-1:0] r_wr_ptr;
    logic [SLAB_W:0]   r_count;

    function automatic logic [SLAB_W-1:0] ptr_inc(input logic [SLAB_W-1:0] p);
        return (32'(p) == NUM_SLABS - 1) ? '0 : p + 1'b1;
    endfunction

    // Full after reset, so the write pointer starts equal to the read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLABS; i++)
                r_fifo[i] <= SLAB_W'(i);
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= (SLAB_W+1)'(NUM_SLABS);
        end else begin
            if (i_push) begin
                r_fifo[r_wr_ptr] <= i_push_slab;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (i_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_fifo[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/tcp_rx_tmp_buf_wr.sv
// ---------------------------------------------------------------------------
// tcp_rx_tmp_buf_wr
// Receive-side payload writer: takes a packet header plus a length-framed
// beat stream, stores accepted payloads into a slab of the temporary buffer
// and emits one rx_store_buf_q_struct entry per packet.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   src_tmp_buf_hdr_*              header (val/flowid/accept/len), hdr_rdy back
//   src_tmp_buf_data(_val)         payload beats, tmp_buf_src_data_rdy back
//   tmp_buf_mem_wr_*               registered slab memory write port
//   tmp_buf_dst_q_val/_data        store-buffer queue entry, dst_tmp_buf_q_rdy
//   src_tmp_buf_free_val/_slab     slab release from downstream
//   tmp_buf_free_cnt               number of free slabs
// Optional macro TCP_RX_TMP_BUF_STATS_EN adds tmp_buf_stat_store_cnt,
// tmp_buf_stat_drop_cnt and tmp_buf_stat_stall_cycles (32-bit, wrapping).
// ---------------------------------------------------------------------------
module tcp_rx_tmp_buf_wr
    import tcp_rx_tmp_buf_wr_pkg::*;
#(
    parameter int DATA_W     = MAC_INTERFACE_W,
    parameter int NUM_SLABS  = RX_TMP_BUF_NUM_SLABS,
    parameter int SLAB_BYTES = RX_TMP_BUF_SLAB_BYTES
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               src_tmp_buf_hdr_val,
    input  logic [FLOWID_W-1:0]                src_tmp_buf_hdr_flowid,
    input  logic                               src_tmp_buf_hdr_accept,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0]     src_tmp_buf_hdr_len,
    output logic                               tmp_buf_src_hdr_rdy,
    input  logic                               src_tmp_buf_data_val,
    input  logic [DATA_W-1:0]                  src_tmp_buf_data,
    output logic                               tmp_buf_src_data_rdy,
    output logic                               tmp_buf_mem_wr_val,
    output logic [RX_TMP_BUF_MEM_ADDR_W-1:0]   tmp_buf_mem_wr_addr,
    output logic [DATA_W-1:0]                  tmp_buf_mem_wr_data,
    output logic                               tmp_buf_dst_q_val,
    output logic [RX_STORE_BUF_Q_STRUCT_W-1:0] tmp_buf_dst_q_data,
    input  logic                               dst_tmp_buf_q_rdy,
    input  logic                               src_tmp_buf_free_val,
    input  logic [RX_TMP_BUF_SLAB_NUM_W-1:0]   src_tmp_buf_free_slab,
`ifdef TCP_RX_TMP_BUF_STATS_EN
    output logic [31:0]                        tmp_buf_stat_store_cnt,
    output logic [31:0]                        tmp_buf_stat_drop_cnt,
    output logic [31:0]                        tmp_buf_stat_stall_cycles,
`endif
    output logic [RX_TMP_BUF_SLAB_NUM_W:0]     tmp_buf_free_cnt
);

    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int BEAT_IDX_W = $clog2(SLAB_BYTES / BEAT_BYTES);
    localparam int SLAB_W     = RX_TMP_BUF_SLAB_NUM_W;
    localparam int LEN_W      = PAYLOAD_ENTRY_LEN_W;

    rx_tmp_buf_wr_state_e             r_state;
    logic [SLAB_W-1:0]                r_slab;
    logic [LEN_W-1:0]                 r_beat_cnt;
    logic [LEN_W-1:0]                 r_last_beat;
    logic                             r_mem_wr_val;
    logic [RX_TMP_BUF_MEM_ADDR_W-1:0] r_mem_wr_addr;
    logic [DATA_W-1:0]                r_mem_wr_data;
    rx_store_buf_q_struct             r_q_data;

    rx_tmp_buf_hdr_struct             w_hdr;
    rx_tmp_buf_pkt_class_e            w_class;
    logic                             w_hdr_rdy;
    logic                             w_hdr_fire;
    logic                             w_pop;
    logic                             w_data_fire;
    logic                             w_last;
    logic                             w_stall;
    logic [LEN_W-1:0]                 w_last_beat;
    logic [SLAB_W-1:0]                w_head;
    logic [SLAB_W:0]                  w_free_cnt;

    assign w_hdr.flowid = src_tmp_buf_hdr_flowid;
    assign w_hdr.accept = src_tmp_buf_hdr_accept;
    assign w_hdr.len    = src_tmp_buf_hdr_len;
    assign w_class      = rx_tmp_buf_classify(w_hdr, SLAB_BYTES);

    // Only a Store header can stall: Drop/Empty never need a slab.
    assign w_stall     = (r_state == ST_IDLE) && (w_class == PKT_STORE) && (w_free_cnt == '0);
    assign w_hdr_rdy   = (r_state == ST_IDLE) && !((w_class == PKT_STORE) && (w_free_cnt == '0));
    assign w_hdr_fire  = src_tmp_buf_hdr_val && w_hdr_rdy;
    assign w_pop       = w_hdr_fire && (w_class == PKT_STORE);
    assign w_data_fire = src_tmp_buf_data_val && tmp_buf_src_data_rdy;
    assign w_last      = (r_beat_cnt == r_last_beat);
    // Index of the final beat; meaningless for len==0, which never enters WRITE/DRAIN.
    assign w_last_beat = LEN_W'((32'(w_hdr.len) + BEAT_BYTES - 1) / BEAT_BYTES - 1);

    rx_tmp_buf_free_list #(
        .NUM_SLABS (NUM_SLABS),
        .SLAB_W    (SLAB_W)
    ) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .i_push      (src_tmp_buf_free_val),
        .i_push_slab (src_tmp_buf_free_slab),
        .o_count     (w_free_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_slab        <= '0;
            r_beat_cnt    <= '0;
            r_last_beat   <= '0;
            r_mem_wr_val  <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_q_data      <= '0;
        end else begin
            r_mem_wr_val <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hdr_fire) begin
                        r_slab                  <= w_head;
                        r_beat_cnt              <= '0;
                        r_last_beat             <= w_last_beat;
                        r_q_data.flowid         <= w_hdr.flowid;
                        r_q_data.accept_payload <= (w_class == PKT_STORE);
                        r_q_data.payload_addr   <= (w_class == PKT_STORE) ?
                                                   32'(w_head) * 32'(SLAB_BYTES) : 32'd0;
                        r_q_data.payload_len    <= w_hdr.len;
                        case (w_class)
                            PKT_STORE: r_state <= ST_WRITE;
                            PKT_DROP:  r_state <= ST_DRAIN;
                            default:   r_state <= ST_OUT;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (w_data_fire) begin
                        r_mem_wr_val  <= 1'b1;
                        r_mem_wr_addr <= RX_TMP_BUF_MEM_ADDR_W'({r_slab, r_beat_cnt[BEAT_IDX_W-1:0]});
                        r_mem_wr_data <= src_tmp_buf_data;
                        r_beat_cnt    <= r_beat_cnt + 1'b1;
                        if (w_last)
                            r_state <= ST_OUT;
                    end
                end
                ST_DRAIN: begin
                    if (w_data_fire) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last)
                            r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (dst_tmp_buf_q_rdy)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tmp_buf_src_hdr_rdy  = w_hdr_rdy;
    assign tmp_buf_src_data_rdy = (r_state == ST_WRITE) || (r_state == ST_DRAIN);
    assign tmp_buf_mem_wr_val   = r_mem_wr_val;
    assign tmp_buf_mem_wr_addr  = r_mem_wr_addr;
    assign tmp_buf_mem_wr_data  = r_mem_wr_data;
    assign tmp_buf_dst_q_val    = (r_state == ST_OUT);
    assign tmp_buf_dst_q_data   = r_q_data;
    assign tmp_buf_free_cnt     = w_free_cnt;

`ifdef TCP_RX_TMP_BUF_STATS_EN
    logic [31:0] r_stat_store;
    logic [31:0] r_stat_drop;
    logic [31:0] r_stat_stall;

    // Stall cycles count only while a Store header is actually waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_store <= '0;
            r_stat_drop  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_hdr_fire && (w_class == PKT_STORE))
                r_stat_store <= r_stat_store + 32'd1;
            if (w_hdr_fire && (w_class == PKT_DROP))
                r_stat_drop <= r_stat_drop + 32'd1;
            if (src_tmp_buf_hdr_val && w_stall)
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign tmp_buf_stat_store_cnt    = r_stat_store;
    assign tmp_buf_stat_drop_cnt     = r_stat_drop;
    assign tmp_buf_stat_stall_cycles = r_stat_stall;
`else
    logic w_unused_stall;
    assign w_unused_stall = w_stall;
`endif

endmodule

// File: tb/tb_tcp_rx_tmp_buf_wr.sv
// Scoreboard bench for tcp_rx_tmp_buf_wr: stimulus pushes expected memory
// writes and queue entries; a negedge monitor pops and compares them.
module tb_tcp_rx_tmp_buf_wr;
    import tcp_rx_tmp_buf_wr_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               hdr_val;
    logic [FLOWID_W-1:0]                hdr_flowid;
    logic                               hdr_accept;
    logic [PAYLOAD_ENTRY_LEN_W-1:0]     hdr_len;
    logic                               hdr_rdy;
    logic                               data_val;
    logic [511:0]                       data;
    logic                               data_rdy;
    logic                               mem_wr_val;
    logic [RX_TMP_BUF_MEM_ADDR_W-1:0]   mem_wr_addr;
    logic [511:0]                       mem_wr_data;
    logic                               q_val;
    logic [RX_STORE_BUF_Q_STRUCT_W-1:0] q_data;
    logic                               q_rdy;
    logic                               free_val;
    logic [RX_TMP_BUF_SLAB_NUM_W-1:0]   free_slab;
    logic [RX_TMP_BUF_SLAB_NUM_W:0]     free_cnt;
`ifdef TCP_RX_TMP_BUF_STATS_EN
    logic [31:0] stat_store, stat_drop, stat_stall;
`endif

    tcp_rx_tmp_buf_wr dut (
        .clk                    (clk),
        .rst                    (rst),
        .src_tmp_buf_hdr_val    (hdr_val),
        .src_tmp_buf_hdr_flowid (hdr_flowid),
        .src_tmp_buf_hdr_accept (hdr_accept),
        .src_tmp_buf_hdr_len    (hdr_len),
        .tmp_buf_src_hdr_rdy    (hdr_rdy),
        .src_tmp_buf_data_val   (data_val),
        .src_tmp_buf_data       (data),
        .tmp_buf_src_data_rdy   (data_rdy),
        .tmp_buf_mem_wr_val     (mem_wr_val),
        .tmp_buf_mem_wr_addr    (mem_wr_addr),
        .tmp_buf_mem_wr_data    (mem_wr_data),
        .tmp_buf_dst_q_val      (q_val),
        .tmp_buf_dst_q_data     (q_data),
        .dst_tmp_buf_q_rdy      (q_rdy),
        .src_tmp_buf_free_val   (free_val),
        .src_tmp_buf_free_slab  (free_slab),
`ifdef TCP_RX_TMP_BUF_STATS_EN
        .tmp_buf_stat_store_cnt    (stat_store),
        .tmp_buf_stat_drop_cnt     (stat_drop),
        .tmp_buf_stat_stall_cycles (stat_stall),
`endif
        .tmp_buf_free_cnt       (free_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RX_TMP_BUF_MEM_ADDR_W-1:0] addr;
        logic [511:0]                     data;
    } wr_t;

    wr_t                  exp_wr[$];
    rx_store_buf_q_struct exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] beat_data(input int f, input int i);
        logic [511:0] d;
        for (int k = 0; k < 16; k++)
            d[k*32 +: 32] = 32'(f * 4096 + i * 16 + k);
        return d;
    endfunction

    function automatic rx_store_buf_q_struct mk_entry(input int f, input logic acc,
                                                      input int addr, input int len);
        rx_store_buf_q_struct e;
        e.flowid         = FLOWID_W'(f);
        e.accept_payload = acc;
        e.payload_addr   = 32'(addr);
        e.payload_len    = PAYLOAD_ENTRY_LEN_W'(len);
        return e;
    endfunction

    task automatic push_wr(input int addr, input logic [511:0] d);
        wr_t w;
        w.addr = RX_TMP_BUF_MEM_ADDR_W'(addr);
        w.data = d;
        exp_wr.push_back(w);
    endtask

    // Monitor: compare every write and every accepted queue entry.
    always @(negedge clk) begin
        wr_t w;
        rx_store_buf_q_struct e;
        if (!rst) begin
            if (mem_wr_val) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wr got_addr=%0h want=no write", mem_wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 512'(mem_wr_addr), 512'(w.addr));
                    check("wr_data", mem_wr_data, w.data);
                end
            end
            if (q_val && q_rdy) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_q got=%0h want=no entry", q_data);
                end else begin
                    e = exp_q.pop_front();
                    check("q_entry", 512'(q_data), 512'(e));
                end
            end
        end
    end

    // All drivers are called just after a posedge.
    task automatic send_hdr(input int f, input logic acc, input int len);
        int n = 0;
        hdr_val = 1'b1; hdr_flowid = FLOWID_W'(f); hdr_accept = acc;
        hdr_len = PAYLOAD_ENTRY_LEN_W'(len);
        @(negedge clk);
        while (!hdr_rdy && n < 200) begin @(negedge clk); n++; end
        if (!hdr_rdy) begin total++; bad++; $display("FAIL hdr_timeout got=0 want=1"); end
        @(posedge clk); #1;
        hdr_val = 1'b0;
    endtask

    task automatic send_beats(input int f, input int nb);
        for (int i = 0; i < nb; i++) begin
            int n = 0;
            data_val = 1'b1; data = beat_data(f, i);
            @(negedge clk);
            while (!data_rdy && n < 200) begin @(negedge clk); n++; end
            if (!data_rdy) begin total++; bad++; $display("FAIL data_timeout got=0 want=1"); end
            @(posedge clk); #1;
        end
        data_val = 1'b0;
    endtask

    task automatic rel(input int s);
        free_val = 1'b1; free_slab = RX_TMP_BUF_SLAB_NUM_W'(s);
        @(posedge clk); #1;
        free_val = 1'b0;
    endtask

    task automatic store_pkt(input int f, input int len, input int slab);
        int nb = (len + 63) / 64;
        exp_q.push_back(mk_entry(f, 1'b1, slab * 2048, len));
        for (int i = 0; i < nb; i++) push_wr(slab * 32 + i, beat_data(f, i));
        send_hdr(f, 1'b1, len);
        send_beats(f, nb);
        check("st_qval_lat", 512'(q_val), 512'(1));
        check("st_wr_lat", 512'(mem_wr_val), 512'(1));
    endtask

    task automatic drop_pkt(input int f, input logic acc, input int len, input int nb);
        exp_q.push_back(mk_entry(f, 1'b0, 0, len));
        send_hdr(f, acc, len);
        send_beats(f, nb);
        check("dr_qval_lat", 512'(q_val), 512'(1));
        check("dr_no_wr", 512'(mem_wr_val), 512'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_wr.size() != 0 || exp_q.size() != 0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 500) begin total++; bad++; $display("FAIL idle_timeout got=pending want=empty"); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_store_buf_q_struct e;
        rst = 1'b1; hdr_val = 1'b0; hdr_flowid = '0; hdr_accept = 1'b0; hdr_len = '0;
        data_val = 1'b0; data = '0; q_rdy = 1'b1; free_val = 1'b0; free_slab = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_rdy",  512'(hdr_rdy), 512'(1));
        check("rst_data_rdy", 512'(data_rdy), 512'(0));
        check("rst_wr_val",   512'(mem_wr_val), 512'(0));
        check("rst_wr_addr",  512'(mem_wr_addr), 512'(0));
        check("rst_wr_data",  mem_wr_data, 512'(0));
        check("rst_q_val",    512'(q_val), 512'(0));
        check("rst_q_data",   512'(q_data), 512'(0));
        check("rst_free_cnt", 512'(free_cnt), 512'(16));
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // Store len 130 -> slab 0, 3 beats
        store_pkt(1, 130, 0);
        check("t1_free_cnt", 512'(free_cnt), 512'(15));
        // Store len 64 -> slab 1
        store_pkt(2, 64, 1);
        check("t2_free_cnt", 512'(free_cnt), 512'(14));
        // Drop and oversize drain
        drop_pkt(3, 1'b0, 200, 4);
        check("t3_free_cnt", 512'(free_cnt), 512'(14));
        drop_pkt(4, 1'b1, 3000, 47);
        check("t4_free_cnt", 512'(free_cnt), 512'(14));
        // Empty: entry one cycle after header
        exp_q.push_back(mk_entry(5, 1'b0, 0, 0));
        send_hdr(5, 1'b1, 0);
        check("empty_q_lat", 512'(q_val), 512'(1));
        check("empty_no_rdy", 512'(data_rdy), 512'(0));
        wait_idle();

        // Return slabs 0,1 (go to tail), then exhaust all 16
        rel(0); rel(1);
        check("rel_free_cnt", 512'(free_cnt), 512'(16));
        for (int k = 0; k < 16; k++)
            store_pkt(16 + k, 64, (k < 14) ? k + 2 : k - 14);
        wait_idle();
        check("exh_free_cnt", 512'(free_cnt), 512'(0));

        hdr_val = 1'b1; hdr_flowid = FLOWID_W'(40); hdr_accept = 1'b1; hdr_len = 16'd100;
        repeat (3) begin
            @(negedge clk);
            check("exh_hdr_stall", 512'(hdr_rdy), 512'(0));
        end
        @(posedge clk); #1;
        rel(5);
        store_pkt(40, 100, 5);
        wait_idle();
        check("post5_free_cnt", 512'(free_cnt), 512'(0));

        // Release concurrent with a pop
        rel(2);
        check("conc_pre_cnt", 512'(free_cnt), 512'(1));
        exp_q.push_back(mk_entry(41, 1'b1, 2 * 2048, 64));
        push_wr(2 * 32, beat_data(41, 0));
        hdr_val = 1'b1; hdr_flowid = FLOWID_W'(41); hdr_accept = 1'b1; hdr_len = 16'd64;
        free_val = 1'b1; free_slab = 4'd3;
        @(negedge clk);
        check("conc_hdr_rdy", 512'(hdr_rdy), 512'(1));
        @(posedge clk); #1;
        hdr_val = 1'b0; free_val = 1'b0;
        check("conc_free_cnt", 512'(free_cnt), 512'(1));
        send_beats(41, 1);
        wait_idle();

        // Queue backpressure: entry held, header blocked
        q_rdy = 1'b0;
        store_pkt(42, 64, 3);
        e = mk_entry(42, 1'b1, 3 * 2048, 64);
        repeat (5) begin
            @(negedge clk);
            check("bp_q_val", 512'(q_val), 512'(1));
            check("bp_q_hold", 512'(q_data), 512'(e));
            check("bp_hdr_rdy", 512'(hdr_rdy), 512'(0));
        end
        @(posedge clk); #1;
        q_rdy = 1'b1;
        wait_idle();

        // Reset in the middle of WRITE
        rel(7);
        push_wr(7 * 32 + 0, beat_data(43, 0));
        push_wr(7 * 32 + 1, beat_data(43, 1));
        send_hdr(43, 1'b1, 256);
        check("mid_free_cnt", 512'(free_cnt), 512'(0));
        send_beats(43, 2);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("mrst_free_cnt", 512'(free_cnt), 512'(16));
        check("mrst_hdr_rdy",  512'(hdr_rdy), 512'(1));
        check("mrst_data_rdy", 512'(data_rdy), 512'(0));
        check("mrst_q_val",    512'(q_val), 512'(0));
        check("mrst_q_data",   512'(q_data), 512'(0));
        check("mrst_wr_val",   512'(mem_wr_val), 512'(0));
        check("mrst_wr_seen",  512'(exp_wr.size()), 512'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Free list restored in ascending order
        store_pkt(44, 100, 0);
        check("after_rst_cnt", 512'(free_cnt), 512'(15));
        wait_idle();
        check("end_wr_empty", 512'(exp_wr.size()), 512'(0));
        check("end_q_empty",  512'(exp_q.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
